// File: rtl/restoring_divider.sv
// Sequential 8-bit unsigned restoring divider, one quotient bit per clock.
// Optional feature: define DIV_BY_ZERO_FLAG_EN to finish a divide-by-zero after
// a single RUN cycle and raise div_zero. Otherwise a zero divisor runs the
// normal 8 iterations (quotient 8'hFF, remainder = dividend) and div_zero is 0.
module restoring_divider (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] dividend,
   input  logic [7:0] divisor,
   output logic       busy,
   output logic       done,
   output logic [7:0] quotient,
   output logic [7:0] remainder,
   output logic       div_zero
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StRun  = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   logic [1:0] state_q, state_d;
   logic [8:0] rem_q, rem_d;        // partial remainder R
   logic [7:0] quo_q, quo_d;        // Q: dividend shifts out, quotient bits shift in
   logic [7:0] dvs_q, dvs_d;        // latched divisor
   logic [3:0] cnt_q, cnt_d;        // iteration counter
   logic [7:0] quotient_q, quotient_d;
   logic [7:0] remainder_q, remainder_d;
   logic       div_zero_q, div_zero_d;

   logic [8:0] rem_shift;
   logic [8:0] trial;
   logic [8:0] rem_iter;
   logic [7:0] quo_iter;

   // One restoring step: shift {R, Q} left, subtract divisor, keep result if non-negative.
   always_comb begin
      rem_shift = {rem_q[7:0], quo_q[7]};
      trial     = rem_shift - {1'b0, dvs_q};
      if (!trial[8]) begin
         rem_iter = trial;
         quo_iter = {quo_q[6:0], 1'b1};
      end else begin
         rem_iter = rem_shift;
         quo_iter = {quo_q[6:0], 1'b0};
      end
   end

   // Next-state logic for the FSM, datapath and result registers.
   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      dvs_d       = dvs_q;
      cnt_d       = cnt_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      div_zero_d  = div_zero_q;
      case (state_q)
         StIdle, StDone: begin
            if (start) begin
               dvs_d      = divisor;
               quo_d      = dividend;
               rem_d      = 9'd0;
               cnt_d      = 4'd0;
               div_zero_d = 1'b0;
               state_d    = StRun;
            end else if (state_q == StDone) begin
               state_d = StIdle;
            end
         end
         StRun: begin
`ifdef DIV_BY_ZERO_FLAG_EN
            if (dvs_q == 8'd0) begin
               // No iteration has run yet, so Q still holds the dividend.
               quotient_d  = 8'hFF;
               remainder_d = quo_q;
               div_zero_d  = 1'b1;
               state_d     = StDone;
            end else begin
`else
            begin
`endif
               rem_d = rem_iter;
               quo_d = quo_iter;
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == 4'd7) begin
                  quotient_d  = quo_iter;
                  remainder_d = rem_iter[7:0];
                  state_d     = StDone;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers with synchronous reset taking priority over everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         rem_q       <= 9'd0;
         quo_q       <= 8'd0;
         dvs_q       <= 8'd0;
         cnt_q       <= 4'd0;
         quotient_q  <= 8'd0;
         remainder_q <= 8'd0;
         div_zero_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         dvs_q       <= dvs_d;
         cnt_q       <= cnt_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         div_zero_q  <= div_zero_d;
      end
   end

   // Status and results come straight from registers.
   always_comb begin
      busy      = (state_q == StRun);
      done      = (state_q == StDone);
      quotient  = quotient_q;
      remainder = remainder_q;
      div_zero  = div_zero_q;
   end

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: directed cases plus random operands
// checked against plain integer division.
module tb_restoring_divider;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] dividend = 8'd0;
   logic [7:0] divisor = 8'd0;
   logic       busy;
   logic       done;
   logic [7:0] quotient;
   logic [7:0] remainder;
   logic       div_zero;

   int checks = 0;
   int failures = 0;

`ifdef DIV_BY_ZERO_FLAG_EN
   localparam bit FlagEn = 1'b1;
`else
   localparam bit FlagEn = 1'b0;
`endif

   restoring_divider dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: integer division; zero divisor gives all-ones quotient and remainder=dividend.
   task automatic model(input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] q, output logic [7:0] r, output logic z,
                        output int lat);
      if (b == 8'd0) begin
         q   = 8'hFF;
         r   = a;
         z   = FlagEn;
         lat = FlagEn ? 1 : 8;
      end else begin
         q   = 8'(int'(a) / int'(b));
         r   = 8'(int'(a) % int'(b));
         z   = 1'b0;
         lat = 8;
      end
   endtask

   // Called just after the accepting edge; returns cycles until done and busy cycles seen.
   task automatic wait_done(output int cyc, output int busy_cnt);
      cyc = 0;
      busy_cnt = 0;
      while (!done && cyc < 30) begin
         if (busy) busy_cnt++;
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b);
      logic [7:0] eq, er;
      logic       ez;
      int         lat, cyc, bc;
      model(a, b, eq, er, ez, lat);
      @(negedge clk);
      start = 1'b1;
      dividend = a;
      divisor = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      // Scramble operand inputs: the divider must not re-sample them during RUN.
      dividend = 8'($urandom);
      divisor = 8'($urandom);
      wait_done(cyc, bc);
      check({tag, " latency"}, cyc, lat);
      check({tag, " busy_cycles"}, bc, lat);
      check({tag, " busy_at_done"}, busy, 0);
      check({tag, " quotient"}, quotient, eq);
      check({tag, " remainder"}, remainder, er);
      check({tag, " div_zero"}, div_zero, ez);
      @(posedge clk);
      #1;
      check({tag, " done_pulse"}, done, 0);
   endtask

   initial begin
      int cyc, bc, done_seen;
      logic [7:0] a, b;

      // Reset
      repeat (2) @(posedge clk);
      #1;
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      check("rst quotient", quotient, 0);
      check("rst remainder", remainder, 0);
      check("rst div_zero", div_zero, 0);
      @(negedge clk);
      rst = 1'b0;

      // Directed operands
      run_op("100/7", 8'd100, 8'd7);
      repeat (4) @(posedge clk);
      #1;
      check("idle hold quotient", quotient, 14);
      check("idle hold remainder", remainder, 2);
      check("idle done", done, 0);
      run_op("255/1", 8'd255, 8'd1);
      run_op("5/9", 8'd5, 8'd9);
      run_op("0/3", 8'd0, 8'd3);
      run_op("77/0", 8'd77, 8'd0);
      run_op("9/2 after div0", 8'd9, 8'd2);
      check("div_zero cleared", div_zero, 0);

      // start during RUN is ignored
      @(negedge clk);
      start = 1'b1;
      dividend = 8'd200;
      divisor = 8'd10;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      start = 1'b1;
      dividend = 8'd50;
      divisor = 8'd5;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(cyc, bc);
      check("ignore_start latency", cyc, 7);
      check("ignore_start quotient", quotient, 20);
      check("ignore_start remainder", remainder, 0);
      done_seen = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (done) done_seen++;
      end
      check("ignore_start single_done", done_seen, 0);

      // Reset during the 4th RUN cycle aborts
      @(negedge clk);
      start = 1'b1;
      dividend = 8'd100;
      divisor = 8'd7;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("abort busy", busy, 0);
      check("abort done", done, 0);
      check("abort quotient", quotient, 0);
      check("abort remainder", remainder, 0);
      check("abort div_zero", div_zero, 0);
      done_seen = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (done) done_seen++;
      end
      check("abort no_done", done_seen, 0);
      run_op("9/2", 8'd9, 8'd2);

      // start held high: back-to-back results every 9 cycles
      @(negedge clk);
      start = 1'b1;
      dividend = 8'd60;
      divisor = 8'd7;
      @(posedge clk);
      #1;
      wait_done(cyc, bc);
      check("b2b first latency", cyc, 8);
      check("b2b first quotient", quotient, 8);
      check("b2b first remainder", remainder, 4);
      for (int n = 0; n < 3; n++) begin
         @(posedge clk);
         #1;
         check("b2b done_drop", done, 0);
         check("b2b restart busy", busy, 1);
         wait_done(cyc, bc);
         check("b2b period", cyc + 1, 9);
         check("b2b quotient", quotient, 8);
         check("b2b remainder", remainder, 4);
      end
      @(negedge clk);
      start = 1'b0;
      repeat (12) @(posedge clk);

      // Random operands, occasionally zero divisor
      for (int i = 0; i < 24; i++) begin
         a = 8'($urandom);
         b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
         run_op($sformatf("rand%0d %0d/%0d", i, a, b), a, b);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
